// File: rtl/ddr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ddr_arb_pkg
// Brief   : Shared types and helpers for the DDR read-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package ddr_arb_pkg;

  // Largest number of client ports the arbiter is dimensioned for
  localparam int MAX_PORTS = 8;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  // Ceiling log2, minimum 1 so a 2-port pointer still has a bit
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : ddr_rr_pick
// Brief   : Combinational round-robin picker. Chooses the first requester at
//           or after ptr_i (wrapping). In priority mode port 0 wins outright
//           and is excluded from the rotating search.
// Revision: 1.0 - initial release
// ============================================================================
module ddr_rr_pick
  import ddr_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  input  logic                 prio_i,
  output logic                 valid_o,
  output logic [NUM_PORTS-1:0] gnt_oh_o,
  output logic [PTR_W-1:0]     gnt_idx_o
);

  logic [NUM_PORTS-1:0] rr_req;

  // Port 0 leaves the rotating pool when it has strict priority
  always_comb begin
    rr_req = req_i;
    if (prio_i) rr_req[0] = 1'b0;
  end

  // Scan from the pointer, first hit wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    valid_o   = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    idx       = '0;
    if (prio_i && req_i[0]) begin
      valid_o     = 1'b1;
      gnt_oh_o[0] = 1'b1;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = PTR_W'((int'(ptr_i) + k) % NUM_PORTS);
        if (!valid_o && rr_req[idx]) begin
          valid_o       = 1'b1;
          gnt_oh_o[idx] = 1'b1;
          gnt_idx_o     = idx;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddr_rd_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ddr_rd_port_arbiter
// Brief   : N-port round-robin read arbiter in front of the single DDR read
//           channel. One command per grant; return beats are steered to the
//           port that won. Optional build macro DDR_ARB_PRIO_EN gives port 0
//           strict priority and rotates the pointer over ports 1..N-1 only.
// Revision: 1.0 - initial release
// ============================================================================
module ddr_rd_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 256,
  parameter int LEN_W     = 4
) (
  input  logic                        ddr_clk,
  input  logic                        rstn,
  input  logic [NUM_PORTS-1:0]        p_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
  input  logic [NUM_PORTS*LEN_W-1:0]  p_len,
  output logic [NUM_PORTS-1:0]        p_ack,
  output logic [NUM_PORTS-1:0]        p_rvalid,
  output logic [DATA_W-1:0]           p_rdata,
  output logic [NUM_PORTS-1:0]        p_done,
  output logic                        rd_req,
  output logic [ADDR_W-1:0]           rd_addr,
  output logic [LEN_W-1:0]            arlen,
  input  logic                        rd_busy,
  input  logic [DATA_W-1:0]           rd_data,
  input  logic                        rdata_valid,
  output logic                        stray_beat
);

  localparam int PTR_W = clog2(NUM_PORTS);

`ifdef DDR_ARB_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  arb_state_e           state_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     rr_ptr_d;
  logic [PTR_W-1:0]     gnt_q;
  logic [NUM_PORTS-1:0] gnt_oh_q;
  logic [LEN_W-1:0]     beat_cnt_q;
  logic                 rd_req_q;
  logic [NUM_PORTS-1:0] p_ack_q;
  logic [NUM_PORTS-1:0] p_rvalid_q;
  logic [NUM_PORTS-1:0] p_done_q;
  logic [DATA_W-1:0]    p_rdata_q;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic [LEN_W-1:0]     arlen_q;
  logic                 stray_q;

  logic                 pick_valid;
  logic [NUM_PORTS-1:0] pick_oh;
  logic [PTR_W-1:0]     pick_idx;
  logic [ADDR_W-1:0]    win_addr;
  logic [LEN_W-1:0]     win_len;

  ddr_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_pick (
    .req_i     (p_req),
    .ptr_i     (rr_ptr_q),
    .prio_i    (PRIO_EN),
    .valid_o   (pick_valid),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx)
  );

  // Select the winning port's command fields from the flattened buses
  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (pick_oh[k]) begin
        win_addr = p_addr[k*ADDR_W +: ADDR_W];
        win_len  = p_len[k*LEN_W +: LEN_W];
      end
    end
  end

  // Pointer moves one past the granted port; port-0 grants leave it alone in priority mode
  always_comb begin
    rr_ptr_d = rr_ptr_q;
`ifdef DDR_ARB_PRIO_EN
    if (gnt_q != '0) begin
      if (int'(gnt_q) == NUM_PORTS - 1) rr_ptr_d = PTR_W'(1);
      else                              rr_ptr_d = gnt_q + PTR_W'(1);
    end
`else
    if (int'(gnt_q) == NUM_PORTS - 1) rr_ptr_d = '0;
    else                              rr_ptr_d = gnt_q + PTR_W'(1);
`endif
  end

  // Arbiter FSM with registered command, ack and return-path outputs
  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      gnt_oh_q   <= '0;
      beat_cnt_q <= '0;
      rd_req_q   <= 1'b0;
      p_ack_q    <= '0;
      p_rvalid_q <= '0;
      p_done_q   <= '0;
      p_rdata_q  <= '0;
      rd_addr_q  <= '0;
      arlen_q    <= '0;
      stray_q    <= 1'b0;
    end else begin
      rd_req_q   <= 1'b0;
      p_ack_q    <= '0;
      p_rvalid_q <= '0;
      p_done_q   <= '0;
      if (rdata_valid && (state_q != DATA)) stray_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pick_valid && !rd_busy) begin
            state_q    <= ISSUE;
            gnt_q      <= pick_idx;
            gnt_oh_q   <= pick_oh;
            rd_addr_q  <= win_addr;
            arlen_q    <= win_len;
            beat_cnt_q <= win_len;
            rd_req_q   <= 1'b1;
            p_ack_q    <= pick_oh;
          end
        end
        ISSUE: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= DATA;
        end
        DATA: begin
          if (rdata_valid) begin
            p_rdata_q  <= rd_data;
            p_rvalid_q <= gnt_oh_q;
            if (beat_cnt_q == '0) begin
              p_done_q <= gnt_oh_q;
              state_q  <= IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q - LEN_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign arlen      = arlen_q;
  assign p_ack      = p_ack_q;
  assign p_rvalid   = p_rvalid_q;
  assign p_done     = p_done_q;
  assign p_rdata    = p_rdata_q;
  assign stray_beat = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ddr_rd_port_arbiter
// Brief   : Directed self-checking bench for ddr_rd_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ddr_rd_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
`ifdef DDR_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic             ddr_clk;
  logic             rstn;
  logic [NP-1:0]    p_req;
  logic [NP*AW-1:0] p_addr;
  logic [NP*LW-1:0] p_len;
  logic [NP-1:0]    p_ack;
  logic [NP-1:0]    p_rvalid;
  logic [DW-1:0]    p_rdata;
  logic [NP-1:0]    p_done;
  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic [LW-1:0]    arlen;
  logic             rd_busy;
  logic [DW-1:0]    rd_data;
  logic             rdata_valid;
  logic             stray_beat;

  int errors = 0;
  int checks = 0;

  ddr_rd_port_arbiter #(
    .NUM_PORTS (NP), .ADDR_W (AW), .DATA_W (DW), .LEN_W (LW)
  ) dut (
    .ddr_clk     (ddr_clk),
    .rstn        (rstn),
    .p_req       (p_req),
    .p_addr      (p_addr),
    .p_len       (p_len),
    .p_ack       (p_ack),
    .p_rvalid    (p_rvalid),
    .p_rdata     (p_rdata),
    .p_done      (p_done),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .arlen       (arlen),
    .rd_busy     (rd_busy),
    .rd_data     (rd_data),
    .rdata_valid (rdata_valid),
    .stray_beat  (stray_beat)
  );

  initial ddr_clk = 1'b0;
  always #5 ddr_clk = ~ddr_clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l);
    p_addr[p*AW +: AW] = a;
    p_len[p*LW +: LW]  = l;
  endtask

  // Present one return beat for one cycle
  task automatic beat(input logic [DW-1:0] d);
    rd_data     = d;
    rdata_valid = 1'b1;
    tick();
    rdata_valid = 1'b0;
  endtask

  // Wait (bounded) until rd_req is seen
  task automatic wait_cmd(output bit got);
    got = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (rd_req) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %0h want 0", rd_req); end
    checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0h want 0", rd_addr); end
    checks++; if (arlen !== '0) begin errors++; $display("FAIL reset_arlen: got %0h want 0", arlen); end
    checks++; if ({p_ack, p_rvalid, p_done} !== '0) begin errors++; $display("FAIL reset_port_flags: got %0h want 0", {p_ack, p_rvalid, p_done}); end
    checks++; if (p_rdata !== '0) begin errors++; $display("FAIL reset_p_rdata: got %0h want 0", p_rdata); end
    checks++; if (stray_beat !== 1'b0) begin errors++; $display("FAIL reset_stray: got %0h want 0", stray_beat); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_port(2, 32'h1000, 4'd3);
    p_req = 4'b0100;
    tick();
    checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL single_rd_req: got %0h want 1", rd_req); end
    checks++; if (p_ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %0h want 4", p_ack); end
    checks++; if (rd_addr !== 32'h1000) begin errors++; $display("FAIL single_addr: got %0h want 1000", rd_addr); end
    checks++; if (arlen !== 4'd3) begin errors++; $display("FAIL single_arlen: got %0h want 3", arlen); end
    p_req = '0;
    tick();
    checks++; if ({rd_req, p_ack} !== '0) begin errors++; $display("FAIL single_pulse_width: got %0h want 0", {rd_req, p_ack}); end
    for (int b = 0; b < 4; b++) begin
      beat(32'hD000 + b);
      checks++; if (p_rvalid !== 4'b0100) begin errors++; $display("FAIL single_rvalid%0d: got %0h want 4", b, p_rvalid); end
      checks++; if (p_rdata !== 32'hD000 + b) begin errors++; $display("FAIL single_rdata%0d: got %0h want %0h", b, p_rdata, 32'hD000 + b); end
      checks++; if (p_done !== ((b == 3) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_done%0d: got %0h want %0h", b, p_done, (b == 3) ? 4'b0100 : 4'b0000); end
    end
    checks++; if (rd_addr !== 32'h1000) begin errors++; $display("FAIL single_addr_hold: got %0h want 1000", rd_addr); end
    tick();
    checks++; if ({p_rvalid, p_done} !== '0) begin errors++; $display("FAIL single_after: got %0h want 0", {p_rvalid, p_done}); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    bit got;
    logic [NP-1:0] e;
    pulse_reset();
    for (int i = 0; i < NP; i++) set_port(i, 32'h100 * (i + 1), 4'd0);
    p_req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      int x;
      x = PRIO ? 0 : order[n];
      e = '0;
      e[x] = 1'b1;
      wait_cmd(got);
      checks++;
      if (!got) begin errors++; $display("FAIL rr_timeout%0d: got no rd_req want rd_req", n); p_req = '0; return; end
      checks++; if (p_ack !== e) begin errors++; $display("FAIL rr_ack%0d: got %0h want %0h", n, p_ack, e); end
      checks++; if (!$onehot(p_ack)) begin errors++; $display("FAIL rr_onehot%0d: got %0h want one-hot", n, p_ack); end
      checks++; if (rd_addr !== 32'h100 * (x + 1)) begin errors++; $display("FAIL rr_addr%0d: got %0h want %0h", n, rd_addr, 32'h100 * (x + 1)); end
      tick();
      beat(32'hA0 + n);
      checks++; if ({p_rvalid, p_done} !== {e, e}) begin errors++; $display("FAIL rr_beat%0d: got %0h want %0h", n, {p_rvalid, p_done}, {e, e}); end
    end
    p_req = '0;
    tick();
  endtask

  task automatic test_busy();
    set_port(1, 32'h2000, 4'd0);
    rd_busy = 1'b1;
    p_req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL busy_hold%0d: got %0h want 0", i, rd_req); end
    end
    rd_busy = 1'b0;
    tick();
    checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL busy_release: got %0h want 1", rd_req); end
    checks++; if (p_ack !== 4'b0010) begin errors++; $display("FAIL busy_ack: got %0h want 2", p_ack); end
    p_req = '0;
    tick();
    beat(32'hB0B0);
    checks++; if (p_done !== 4'b0010) begin errors++; $display("FAIL busy_done: got %0h want 2", p_done); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit got;
    set_port(1, 32'h2400, 4'd0);
    p_req = 4'b0010;
    wait_cmd(got);
    checks++; if (!got) begin errors++; $display("FAIL b2b_timeout: got no rd_req want rd_req"); p_req = '0; return; end
    tick();
    beat(32'hC1);
    checks++; if (p_done !== 4'b0010) begin errors++; $display("FAIL b2b_done1: got %0h want 2", p_done); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %0h want 0", rd_req); end
    tick();
    checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL b2b_second_req: got %0h want 1", rd_req); end
    p_req = '0;
    tick();
    beat(32'hC2);
    checks++; if ({p_done, p_rdata} !== {4'b0010, 32'hC2}) begin errors++; $display("FAIL b2b_done2: got %0h want %0h", {p_done, p_rdata}, {4'b0010, 32'hC2}); end
    tick();
  endtask

  task automatic test_stray();
    checks++; if (stray_beat !== 1'b0) begin errors++; $display("FAIL stray_pre: got %0h want 0", stray_beat); end
    rd_data = 32'hBAD;
    rdata_valid = 1'b1;
    tick();
    rdata_valid = 1'b0;
    checks++; if (p_rvalid !== '0) begin errors++; $display("FAIL stray_rvalid: got %0h want 0", p_rvalid); end
    checks++; if (stray_beat !== 1'b1) begin errors++; $display("FAIL stray_set: got %0h want 1", stray_beat); end
    tick(); tick(); tick();
    checks++; if (stray_beat !== 1'b1) begin errors++; $display("FAIL stray_sticky: got %0h want 1", stray_beat); end
  endtask

  task automatic test_reset_mid();
    bit got;
    set_port(0, 32'h4000, 4'd7);
    p_req = 4'b0001;
    wait_cmd(got);
    checks++; if (!got) begin errors++; $display("FAIL mid_timeout: got no rd_req want rd_req"); p_req = '0; return; end
    checks++; if (arlen !== 4'd7) begin errors++; $display("FAIL mid_arlen: got %0h want 7", arlen); end
    p_req = '0;
    tick();
    beat(32'hE1);
    beat(32'hE2);
    checks++; if (p_rvalid !== 4'b0001) begin errors++; $display("FAIL mid_beat2: got %0h want 1", p_rvalid); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if ({rd_req, p_ack, p_rvalid, p_done, stray_beat} !== '0) begin errors++; $display("FAIL mid_flags: got %0h want 0", {rd_req, p_ack, p_rvalid, p_done, stray_beat}); end
    checks++; if ({rd_addr, arlen, p_rdata} !== '0) begin errors++; $display("FAIL mid_data: got %0h want 0", {rd_addr, arlen, p_rdata}); end
    #2;
    rstn = 1'b1;
    tick();
    tick();
    checks++; if (p_done !== '0) begin errors++; $display("FAIL mid_no_done: got %0h want 0", p_done); end
    set_port(3, 32'h3000, 4'd1);
    p_req = 4'b1000;
    tick();
    checks++; if ({rd_req, p_ack} !== 5'b11000) begin errors++; $display("FAIL mid_next_cmd: got %0h want 18", {rd_req, p_ack}); end
    checks++; if (rd_addr !== 32'h3000) begin errors++; $display("FAIL mid_next_addr: got %0h want 3000", rd_addr); end
    p_req = '0;
    tick();
    beat(32'hF1);
    checks++; if ({p_rvalid, p_done} !== 8'h80) begin errors++; $display("FAIL mid_next_b1: got %0h want 80", {p_rvalid, p_done}); end
    beat(32'hF2);
    checks++; if ({p_rvalid, p_done} !== 8'h88) begin errors++; $display("FAIL mid_next_b2: got %0h want 88", {p_rvalid, p_done}); end
    tick();
  endtask

  task automatic test_two_ports();
    bit got;
    logic [NP-1:0] e;
    pulse_reset();
    set_port(0, 32'h10, 4'd0);
    set_port(3, 32'h30, 4'd0);
    p_req = 4'b1001;
    for (int n = 0; n < 4; n++) begin
      if (PRIO && n == 3) p_req = 4'b1000;
      if (PRIO) e = (n == 3) ? 4'b1000 : 4'b0001;
      else      e = (n % 2 == 1) ? 4'b1000 : 4'b0001;
      wait_cmd(got);
      checks++;
      if (!got) begin errors++; $display("FAIL two_timeout%0d: got no rd_req want rd_req", n); p_req = '0; return; end
      checks++; if (p_ack !== e) begin errors++; $display("FAIL two_ack%0d: got %0h want %0h", n, p_ack, e); end
      tick();
      beat(32'h77 + n);
      checks++; if (p_done !== e) begin errors++; $display("FAIL two_done%0d: got %0h want %0h", n, p_done, e); end
    end
    p_req = '0;
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    p_req = '0;
    p_addr = '0;
    p_len = '0;
    rd_busy = 1'b0;
    rd_data = '0;
    rdata_valid = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_busy();
    test_back_to_back();
    test_stray();
    test_reset_mid();
    test_two_ports();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
